// File: rtl/shift_seq_if.sv
// Request/response bundle between the shift sequencer and the stage that drives it.
// The requester uses the master modport; the sequencer uses the slave modport.
interface shift_seq_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             start;
   logic [WIDTH-1:0] data;
   logic [SHW-1:0]   amt;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, data, amt, op,
      input  busy, done, result
   );

   modport slave (
      input  start, data, amt, op,
      output busy, done, result
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: moves the operand one bit per clock until the
// captured amount is exhausted, then raises done for a single cycle.
module shift_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic       clock,
   input  logic       resetn,
   shift_seq_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
   localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

   logic [1:0]       state_q,  state_d;
   logic [SHW-1:0]   count_q,  count_d;
   logic [1:0]       op_q,     op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q;
   logic             done_q;

   // Next-state, shift-register and down-counter logic.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               result_d = bus.data;
               count_d  = bus.amt;
               op_d     = bus.op;
               if (bus.amt == CNT_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            case (op_q)
               2'b00:   result_d = {1'b0, result_q[WIDTH-1:1]};
               2'b01:   result_d = {result_q[WIDTH-2:0], 1'b0};
               2'b10:   result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
               2'b11:   result_d = {result_q[0], result_q[WIDTH-1:1]};
               default: result_d = result_q;
            endcase
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; busy/done are registered from the next state so they track it exactly.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         count_q  <= CNT_ZERO;
         op_q     <= 2'b00;
         result_q <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         result_q <= result_d;
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_DONE);
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: expected results and latencies are queued
// at issue time from a bit-serial reference model and popped when done fires.
module tb_shift_seq;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] exp_q[$];
   int          lat_q[$];

   shift_seq_if #(.WIDTH(32), .SHW(5)) bus ();

   shift_seq #(.WIDTH(32), .SHW(5)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic [1:0] o);
      logic [31:0] r;
      r = d;
      for (int i = 0; i < a; i++) begin
         case (o)
            2'b00:   r = r >> 1;
            2'b01:   r = r << 1;
            2'b10:   r = $unsigned($signed(r) >>> 1);
            default: r = {r[0], r[31:1]};
         endcase
      end
      return r;
   endfunction

   task automatic issue(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o);
      @(negedge clock);
      bus.start = 1'b1;
      bus.data  = d;
      bus.amt   = a;
      bus.op    = o;
      exp_q.push_back(ref_shift(d, int'(a), o));
      lat_q.push_back(int'(a) + 1);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.data  = ~d;
      bus.amt   = ~a;
      bus.op    = ~o;
   endtask

   task automatic wait_done(output int cycles, output logic [31:0] res, output bit timeout,
                            output logic busy_first);
      bit found;
      found      = 1'b0;
      cycles     = 0;
      res        = 32'h0000_0000;
      busy_first = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clock);
         cycles++;
         if (cycles == 1) busy_first = bus.busy;
         if (bus.done === 1'b1) begin
            found = 1'b1;
            res   = bus.result;
         end
      end
      timeout = !found;
   endtask

   task automatic test_reset();
      int          cyc;
      logic [31:0] res, exp;
      int          lat;
      bit          to;
      logic        b1;
      resetn    = 1'b0;
      bus.start = 1'b0;
      bus.data  = 32'h0000_0000;
      bus.amt   = 5'd0;
      bus.op    = 2'b00;
      repeat (3) @(negedge clock);
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.result !== 32'h0000_0000) $display("FAIL reset_result: got %h want 00000000", bus.result);
      else pass_cnt++;
      // release and request on the same half-cycle: the very next edge must accept
      @(negedge clock);
      resetn    = 1'b1;
      bus.start = 1'b1;
      bus.data  = 32'h8000_0001;
      bus.amt   = 5'd4;
      bus.op    = 2'b00;
      exp_q.push_back(ref_shift(32'h8000_0001, 4, 2'b00));
      lat_q.push_back(5);
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.data  = 32'h0000_0000;
      wait_done(cyc, res, to, b1);
      exp = exp_q.pop_front();
      lat = lat_q.pop_front();
      total_cnt++;
      if (b1 !== 1'b1) $display("FAIL first_busy: got %b want 1", b1);
      else pass_cnt++;
      total_cnt++;
      if (to) $display("FAIL first_timeout: done not seen, want done after %0d cycles", lat);
      else pass_cnt++;
      total_cnt++;
      if (res !== exp || res !== 32'h0800_0000) $display("FAIL first_result: got %h want %h", res, exp);
      else pass_cnt++;
      total_cnt++;
      if (cyc != lat) $display("FAIL first_latency: got %0d want %0d", cyc, lat);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL first_after_done: got busy=%b done=%b want 0/0", bus.busy, bus.done);
      else pass_cnt++;
   endtask

   task automatic test_right_shifts();
      logic [31:0] d_t[2];
      logic [4:0]  a_t[2];
      logic [1:0]  o_t[2];
      int          cyc, lat;
      logic [31:0] res, exp;
      bit          to;
      logic        b1;
      d_t[0] = 32'h8000_0000; a_t[0] = 5'd31; o_t[0] = 2'b10;
      d_t[1] = 32'h8000_0000; a_t[1] = 5'd31; o_t[1] = 2'b00;
      for (int k = 0; k < 2; k++) begin
         issue(d_t[k], a_t[k], o_t[k]);
         wait_done(cyc, res, to, b1);
         exp = exp_q.pop_front();
         lat = lat_q.pop_front();
         total_cnt++;
         if (to) $display("FAIL right%0d_timeout: done not seen, want after %0d cycles", k, lat);
         else pass_cnt++;
         total_cnt++;
         if (res !== exp) $display("FAIL right%0d_result: got %h want %h", k, res, exp);
         else pass_cnt++;
         total_cnt++;
         if (cyc != lat) $display("FAIL right%0d_latency: got %0d want %0d", k, cyc, lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_left_rotate();
      logic [31:0] d_t[3];
      logic [4:0]  a_t[3];
      logic [1:0]  o_t[3];
      int          cyc, lat;
      logic [31:0] res, exp;
      bit          to;
      logic        b1;
      d_t[0] = 32'h0000_0001; a_t[0] = 5'd31; o_t[0] = 2'b01;
      d_t[1] = 32'h0000_0003; a_t[1] = 5'd1;  o_t[1] = 2'b11;
      d_t[2] = 32'h1234_5678; a_t[2] = 5'd12; o_t[2] = 2'b11;
      for (int k = 0; k < 3; k++) begin
         issue(d_t[k], a_t[k], o_t[k]);
         wait_done(cyc, res, to, b1);
         exp = exp_q.pop_front();
         lat = lat_q.pop_front();
         total_cnt++;
         if (to) $display("FAIL lr%0d_timeout: done not seen, want after %0d cycles", k, lat);
         else pass_cnt++;
         total_cnt++;
         if (res !== exp) $display("FAIL lr%0d_result: got %h want %h", k, res, exp);
         else pass_cnt++;
         total_cnt++;
         if (cyc != lat) $display("FAIL lr%0d_latency: got %0d want %0d", k, cyc, lat);
         else pass_cnt++;
      end
   endtask

   task automatic test_zero_amt_ignore();
      int          cyc, lat;
      logic [31:0] res, exp;
      bit          to;
      logic        b1;
      issue(32'hDEAD_BEEF, 5'd0, 2'b00);
      wait_done(cyc, res, to, b1);
      exp = exp_q.pop_front();
      lat = lat_q.pop_front();
      total_cnt++;
      if (res !== exp) $display("FAIL zero_result: got %h want %h", res, exp);
      else pass_cnt++;
      total_cnt++;
      if (to || cyc != lat) $display("FAIL zero_latency: got %0d want %0d", cyc, lat);
      else pass_cnt++;
      // now inside the DONE cycle: this request must be dropped
      bus.start = 1'b1;
      bus.data  = 32'h1234_5678;
      bus.amt   = 5'd5;
      bus.op    = 2'b01;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         total_cnt++;
         if (bus.result !== 32'hDEAD_BEEF || bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL ignore_c%0d: got result=%h busy=%b done=%b want deadbeef/0/0",
                     i, bus.result, bus.busy, bus.done);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] mid;
      logic [31:0] dropped;
      int          dropped_lat;
      int          done_seen;
      issue(32'hF0F0_A5A5, 5'd20, 2'b00);
      repeat (7) @(posedge clock);
      #2;
      mid = ref_shift(32'hF0F0_A5A5, 7, 2'b00);
      total_cnt++;
      if (bus.result !== mid) $display("FAIL abort_mid: got %h want %h", bus.result, mid);
      else pass_cnt++;
      #1;
      resetn = 1'b0;
      #1;
      total_cnt++;
      if (bus.result !== 32'h0000_0000 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL abort_async: got result=%h busy=%b done=%b want 0/0/0",
                  bus.result, bus.busy, bus.done);
      else pass_cnt++;
      dropped     = exp_q.pop_front();
      dropped_lat = lat_q.pop_front();
      @(negedge clock);
      resetn = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (bus.done === 1'b1) done_seen++;
      end
      total_cnt++;
      if (done_seen != 0)
         $display("FAIL abort_no_done: got %0d done pulses want 0 (dropped %h/%0d)",
                  done_seen, dropped, dropped_lat);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int          n_done;
      int          d_cyc[2];
      bit          double_pulse;
      logic        prev_done;
      logic [31:0] exp;
      int          lat;
      n_done       = 0;
      d_cyc[0]     = 0;
      d_cyc[1]     = 0;
      double_pulse = 1'b0;
      prev_done    = 1'b0;
      @(negedge clock);
      bus.start = 1'b1;
      bus.data  = 32'hF000_000F;
      bus.amt   = 5'd3;
      bus.op    = 2'b00;
      exp_q.push_back(ref_shift(32'hF000_000F, 3, 2'b00));
      lat_q.push_back(4);
      @(posedge clock);
      #1;
      bus.data = 32'h0000_C003;
      bus.amt  = 5'd2;
      bus.op   = 2'b01;
      exp_q.push_back(ref_shift(32'h0000_C003, 2, 2'b01));
      lat_q.push_back(3);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clock);
         if (bus.done === 1'b1) begin
            if (prev_done) double_pulse = 1'b1;
            if (n_done < 2) begin
               d_cyc[n_done] = c;
               exp = exp_q.pop_front();
               lat = lat_q.pop_front();
               total_cnt++;
               if (bus.result !== exp) $display("FAIL b2b%0d_result: got %h want %h", n_done, bus.result, exp);
               else pass_cnt++;
            end
            n_done++;
            if (n_done == 2) bus.start = 1'b0;
         end
         prev_done = bus.done;
      end
      bus.start = 1'b0;
      total_cnt++;
      if (n_done != 2) $display("FAIL b2b_count: got %0d done pulses want 2", n_done);
      else pass_cnt++;
      total_cnt++;
      if (d_cyc[0] != 4) $display("FAIL b2b_first_latency: got %0d want 4", d_cyc[0]);
      else pass_cnt++;
      total_cnt++;
      if (d_cyc[1] - d_cyc[0] != 4) $display("FAIL b2b_spacing: got %0d want 4", d_cyc[1] - d_cyc[0]);
      else pass_cnt++;
      total_cnt++;
      if (double_pulse) $display("FAIL b2b_pulse_width: got done high 2 cycles want 1");
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_right_shifts();
      test_left_rotate();
      test_zero_amt_ignore();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
